aon_timer_cfg_seq: RTL and testbench
====================================

// Module: aon_timer_cfg_seq
// PURPOSE
//  Hardware configuration sequencer for the AON timer core write-strobe interface (clk_aon_i domain).
//  Takes one programming request (wakeup + watchdog settings) by req/ack handshake and issues the
//  core register writes in a fixed safe order: disable, clear, program, enable. One strobe per step.
//  Sits beside the register-top strobe path and is ORed into the core write ports by the parent.
// PARAMETERS
//  GapCycles  0  idle cycles inserted between consecutive write steps (0..15)
// PORTS
//  clk_aon_i              in   1   AON clock; single clock domain
//  rst_aon_i              in   1   asynchronous, active-high reset
//  req_i                  in   1   programming request; cfg_*_i valid while req_i=1
//  ack_o                  out  1   comb: req_i & (state==IDLE); cfg captured on req_i&ack_o
//  abort_i                in   1   abandon sequence, disable both timers
//  cfg_wkup_en_i          in   1   final wakeup enable
//  cfg_wkup_presc_i       in   12  wakeup prescaler
//  cfg_wkup_thold_i       in   32  wakeup threshold
//  cfg_wdog_en_i          in   1   final watchdog enable
//  cfg_wdog_pause_i       in   1   watchdog pause_in_sleep
//  cfg_wdog_bark_i        in   32  bark threshold
//  cfg_wdog_bite_i        in   32  bite threshold
//  wkup_ctrl_reg_wr_o / wkup_ctrl_wr_data_o      out 1/13  {prescaler,enable}
//  wkup_thold_reg_wr_o / wkup_thold_wr_data_o    out 1/32
//  wkup_count_reg_wr_o / wkup_count_wr_data_o    out 1/32  data always 0
//  wdog_ctrl_reg_wr_o / wdog_ctrl_wr_data_o      out 1/2   {pause,enable}
//  wdog_bark_thold_reg_wr_o / _wr_data_o         out 1/32
//  wdog_bite_thold_reg_wr_o / _wr_data_o         out 1/32
//  wdog_count_reg_wr_o / wdog_count_wr_data_o    out 1/32  data always 0
//  rb_wkup_thold_i, rb_wdog_bark_i, rb_wdog_bite_i  in 32  core readback (verify only)
//  busy_o                 out  1   state != IDLE
//  done_o                 out  1   one-cycle pulse at sequence end (normal or abort)
//  err_o                  out  1   valid with done_o: abort or verify mismatch
// BEHAVIOUR
//  Reset: state=IDLE, step=0, gap cnt=0; all *_reg_wr_o, done_o, err_o, busy_o = 0; data outs 0.
//  All outputs registered except ack_o. At most one *_reg_wr_o high per cycle except in ABORT.
//  States: IDLE -> WRITE <-> GAP -> (VERIFY) -> IDLE; ABORT -> IDLE from any non-IDLE state.
//  IDLE: on req_i (ack_o=1) latch all cfg_*_i, step=0, go WRITE. req_i in other states: no ack.
//  WRITE step order (step 0..8): 0 wkup_ctrl {presc,0}; 1 wdog_ctrl {pause,0}; 2 wkup_count 0;
//   3 wkup_thold; 4 wdog_count 0; 5 wdog_bark; 6 wdog_bite; 7 wdog_ctrl {pause,wdog_en};
//   8 wkup_ctrl {presc,wkup_en}. Each strobe high exactly one cycle.
//  Timing: accept at cycle 0 -> step k strobe at cycle 1+k*(GapCycles+1); GAP holds GapCycles
//   cycles (skipped if 0). After step 8: done_o at next cycle (GapCycles=0: cycle 10), err_o=0.
//  abort_i (priority over all): in any non-IDLE state, next cycle enter ABORT: wkup_ctrl and
//   wdog_ctrl strobes together with enable=0 (latched presc/pause kept), then IDLE with
//   done_o=1, err_o=1 the following cycle. abort_i in IDLE ignored. req_i+abort_i in IDLE: accept.
//  Reset mid-sequence: immediate return to reset values; no partial strobe completes.
//  Gap counter 4-bit, saturating compare to GapCycles; no wrap.
// CONFIGURATION
//  AON_TIMER_CFG_SEQ_VERIFY_EN defined: after step 8 enter VERIFY for one cycle; compare
//   rb_wkup_thold_i/rb_wdog_bark_i/rb_wdog_bite_i to latched values; done_o next cycle with
//   err_o = any mismatch (GapCycles=0: done at cycle 11). Abort still wins during VERIFY.
//  Not defined: no VERIFY state, rb_* ports present but unused, err_o only from abort.
// STRUCTURE
//  aon_timer_cfg_seq_pkg: state enum (IDLE,WRITE,GAP,VERIFY,ABORT), step enum (9 steps, 4-bit),
//   NumSteps=9, cfg struct typedef (all latched cfg fields).
//  No sub-module; step decoder is a case on step in one always_comb, strobes flopped.
// TESTING
//  1 GapCycles=0, thold=0x100, presc=3, bark=0x40, bite=0x80, en=1/1 -> strobes cycles 1..9 in order,
//    wkup_ctrl data 0x006 then 0x007, done_o cycle 10, err_o=0.
//  2 GapCycles=2 -> strobes at cycles 1,4,...,25; done_o cycle 26; busy_o high cycles 1..25.
//  3 abort_i at cycle 4 -> cycle 5 both ctrl strobes enable=0, cycle 6 done_o=1 err_o=1, idle.
//  4 second req_i while busy -> ack_o=0, no relatch; after done, held req_i acked next IDLE cycle.
//  5 VERIFY_EN, rb_wdog_bite_i=0x81 vs 0x80 -> done_o cycle 11, err_o=1; matching -> err_o=0.
//  6 rst_aon_i pulsed at cycle 3 -> all outputs 0 same cycle, IDLE, no further strobes.

Source files
------------

// File: rtl/aon_timer_cfg_seq_pkg.sv
// Purpose: shared types and constants for the AON timer configuration sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: sequencer state enum, write-step enum, latched configuration
// struct and the registered write-strobe bus struct.
package aon_timer_cfg_seq_pkg;

  localparam int NumSteps = 9;
  localparam int GapCntW  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_GAP    = 3'd2,
    ST_VERIFY = 3'd3,
    ST_ABORT  = 3'd4
  } state_e;

  // Safe programming order: disable both, clear counters, load thresholds, enable.
  typedef enum logic [3:0] {
    STEP_WKUP_CTRL_DIS = 4'd0,
    STEP_WDOG_CTRL_DIS = 4'd1,
    STEP_WKUP_CNT_CLR  = 4'd2,
    STEP_WKUP_THOLD    = 4'd3,
    STEP_WDOG_CNT_CLR  = 4'd4,
    STEP_WDOG_BARK     = 4'd5,
    STEP_WDOG_BITE     = 4'd6,
    STEP_WDOG_CTRL_EN  = 4'd7,
    STEP_WKUP_CTRL_EN  = 4'd8
  } step_e;

  localparam step_e LastStep = step_e'(4'(NumSteps - 1));

  typedef struct packed {
    logic        wkup_en;
    logic [11:0] wkup_presc;
    logic [31:0] wkup_thold;
    logic        wdog_en;
    logic        wdog_pause;
    logic [31:0] wdog_bark;
    logic [31:0] wdog_bite;
  } cfg_t;

  // Counter-clear writes carry no data, so only their strobes are stored.
  typedef struct packed {
    logic        wkup_ctrl_wr;
    logic [12:0] wkup_ctrl_dat;
    logic        wkup_thold_wr;
    logic [31:0] wkup_thold_dat;
    logic        wkup_count_wr;
    logic        wdog_ctrl_wr;
    logic [1:0]  wdog_ctrl_dat;
    logic        wdog_bark_wr;
    logic [31:0] wdog_bark_dat;
    logic        wdog_bite_wr;
    logic [31:0] wdog_bite_dat;
    logic        wdog_count_wr;
  } wr_bus_t;

endpackage

// File: rtl/aon_timer_cfg_seq.sv
// Purpose: issues AON timer core register writes (disable, clear, program, enable) for one request.
// Latency: first strobe 1 cycle after accept; step k at 1+k*(GapCycles+1); done 1 cycle after last step.
// Backpressure: req_i/ack_o handshake; ack_o only in IDLE, requests while busy wait un-acked.
//
// Optional feature macro: AON_TIMER_CFG_SEQ_VERIFY_EN adds a one-cycle readback
// compare after the last write; err_o then also flags a readback mismatch.
//
// Ports:
//   clk_aon_i, rst_aon_i          AON clock, async active-high reset
//   req_i / ack_o                 programming request handshake (cfg_*_i valid with req_i)
//   abort_i                       abandon sequence, write both ctrl regs with enable=0
//   cfg_*_i                       wakeup/watchdog settings latched on accept
//   *_reg_wr_o / *_wr_data_o      core write strobes and data (registered, one per step)
//   rb_*_i                        core readback for the verify cycle
//   busy_o, done_o, err_o         status (registered)
module aon_timer_cfg_seq
  import aon_timer_cfg_seq_pkg::*;
#(
  parameter int GapCycles = 0
) (
  input  logic        clk_aon_i,
  input  logic        rst_aon_i,
  input  logic        req_i,
  output logic        ack_o,
  input  logic        abort_i,
  input  logic        cfg_wkup_en_i,
  input  logic [11:0] cfg_wkup_presc_i,
  input  logic [31:0] cfg_wkup_thold_i,
  input  logic        cfg_wdog_en_i,
  input  logic        cfg_wdog_pause_i,
  input  logic [31:0] cfg_wdog_bark_i,
  input  logic [31:0] cfg_wdog_bite_i,
  output logic        wkup_ctrl_reg_wr_o,
  output logic [12:0] wkup_ctrl_wr_data_o,
  output logic        wkup_thold_reg_wr_o,
  output logic [31:0] wkup_thold_wr_data_o,
  output logic        wkup_count_reg_wr_o,
  output logic [31:0] wkup_count_wr_data_o,
  output logic        wdog_ctrl_reg_wr_o,
  output logic [1:0]  wdog_ctrl_wr_data_o,
  output logic        wdog_bark_thold_reg_wr_o,
  output logic [31:0] wdog_bark_thold_wr_data_o,
  output logic        wdog_bite_thold_reg_wr_o,
  output logic [31:0] wdog_bite_thold_wr_data_o,
  output logic        wdog_count_reg_wr_o,
  output logic [31:0] wdog_count_wr_data_o,
  input  logic [31:0] rb_wkup_thold_i,
  input  logic [31:0] rb_wdog_bark_i,
  input  logic [31:0] rb_wdog_bite_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  state_e               state_q, state_d;
  step_e                step_q, step_d;
  logic [GapCntW-1:0]   gap_cnt_q, gap_cnt_d;
  cfg_t                 cfg_q, cfg_d;
  wr_bus_t              wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  cfg_t                 cfg_in;
  logic                 gap_last;
  step_e                step_next;

  assign cfg_in = '{
    wkup_en:    cfg_wkup_en_i,
    wkup_presc: cfg_wkup_presc_i,
    wkup_thold: cfg_wkup_thold_i,
    wdog_en:    cfg_wdog_en_i,
    wdog_pause: cfg_wdog_pause_i,
    wdog_bark:  cfg_wdog_bark_i,
    wdog_bite:  cfg_wdog_bite_i
  };

  // Counter runs 0..GapCycles-1 inside GAP; compare is one wider so it never wraps.
  assign gap_last  = ({1'b0, gap_cnt_q} + 5'd1) >= 5'(GapCycles);
  assign step_next = step_e'(step_q + 4'd1);

`ifdef AON_TIMER_CFG_SEQ_VERIFY_EN
  logic verify_mismatch;
  assign verify_mismatch = (rb_wkup_thold_i != cfg_q.wkup_thold) |
                           (rb_wdog_bark_i  != cfg_q.wdog_bark)  |
                           (rb_wdog_bite_i  != cfg_q.wdog_bite);
`else
  logic unused_rb;
  assign unused_rb = ^{rb_wkup_thold_i, rb_wdog_bark_i, rb_wdog_bite_i};
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    gap_cnt_d = gap_cnt_q;
    cfg_d     = cfg_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_d      = '0;

    case (state_q)
      ST_IDLE: begin
        // abort_i is meaningless here; a simultaneous request is still taken.
        if (req_i) begin
          cfg_d     = cfg_in;
          step_d    = STEP_WKUP_CTRL_DIS;
          gap_cnt_d = '0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        gap_cnt_d = '0;
        if (step_q == LastStep) begin
`ifdef AON_TIMER_CFG_SEQ_VERIFY_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else if (GapCycles == 0) begin
          step_d = step_next;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          step_d    = step_next;
          state_d   = ST_WRITE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      ST_VERIFY: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
`ifdef AON_TIMER_CFG_SEQ_VERIFY_EN
        err_d   = verify_mismatch;
`endif
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every in-flight transition; ABORT itself is already unwinding.
    if (abort_i && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
      state_d = ST_ABORT;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // Strobes are decoded from the next state so they line up with the state register.
    if (state_d == ST_ABORT) begin
      wr_d.wkup_ctrl_wr  = 1'b1;
      wr_d.wkup_ctrl_dat = {cfg_d.wkup_presc, 1'b0};
      wr_d.wdog_ctrl_wr  = 1'b1;
      wr_d.wdog_ctrl_dat = {cfg_d.wdog_pause, 1'b0};
    end else if (state_d == ST_WRITE) begin
      case (step_d)
        STEP_WKUP_CTRL_DIS: begin
          wr_d.wkup_ctrl_wr  = 1'b1;
          wr_d.wkup_ctrl_dat = {cfg_d.wkup_presc, 1'b0};
        end
        STEP_WDOG_CTRL_DIS: begin
          wr_d.wdog_ctrl_wr  = 1'b1;
          wr_d.wdog_ctrl_dat = {cfg_d.wdog_pause, 1'b0};
        end
        STEP_WKUP_CNT_CLR: wr_d.wkup_count_wr = 1'b1;
        STEP_WKUP_THOLD: begin
          wr_d.wkup_thold_wr  = 1'b1;
          wr_d.wkup_thold_dat = cfg_d.wkup_thold;
        end
        STEP_WDOG_CNT_CLR: wr_d.wdog_count_wr = 1'b1;
        STEP_WDOG_BARK: begin
          wr_d.wdog_bark_wr  = 1'b1;
          wr_d.wdog_bark_dat = cfg_d.wdog_bark;
        end
        STEP_WDOG_BITE: begin
          wr_d.wdog_bite_wr  = 1'b1;
          wr_d.wdog_bite_dat = cfg_d.wdog_bite;
        end
        STEP_WDOG_CTRL_EN: begin
          wr_d.wdog_ctrl_wr  = 1'b1;
          wr_d.wdog_ctrl_dat = {cfg_d.wdog_pause, cfg_d.wdog_en};
        end
        STEP_WKUP_CTRL_EN: begin
          wr_d.wkup_ctrl_wr  = 1'b1;
          wr_d.wkup_ctrl_dat = {cfg_d.wkup_presc, cfg_d.wkup_en};
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
    if (rst_aon_i) begin
      state_q   <= ST_IDLE;
      step_q    <= STEP_WKUP_CTRL_DIS;
      gap_cnt_q <= '0;
      cfg_q     <= '0;
      wr_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      gap_cnt_q <= gap_cnt_d;
      cfg_q     <= cfg_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ack_o = req_i & (state_q == ST_IDLE);

  assign wkup_ctrl_reg_wr_o        = wr_q.wkup_ctrl_wr;
  assign wkup_ctrl_wr_data_o       = wr_q.wkup_ctrl_dat;
  assign wkup_thold_reg_wr_o       = wr_q.wkup_thold_wr;
  assign wkup_thold_wr_data_o      = wr_q.wkup_thold_dat;
  assign wkup_count_reg_wr_o       = wr_q.wkup_count_wr;
  assign wkup_count_wr_data_o      = 32'd0;
  assign wdog_ctrl_reg_wr_o        = wr_q.wdog_ctrl_wr;
  assign wdog_ctrl_wr_data_o       = wr_q.wdog_ctrl_dat;
  assign wdog_bark_thold_reg_wr_o  = wr_q.wdog_bark_wr;
  assign wdog_bark_thold_wr_data_o = wr_q.wdog_bark_dat;
  assign wdog_bite_thold_reg_wr_o  = wr_q.wdog_bite_wr;
  assign wdog_bite_thold_wr_data_o = wr_q.wdog_bite_dat;
  assign wdog_count_reg_wr_o       = wr_q.wdog_count_wr;
  assign wdog_count_wr_data_o      = 32'd0;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_aon_timer_cfg_seq.sv
// Bench for aon_timer_cfg_seq: two instances (GapCycles 0 and 2) share stimulus;
// each is compared every cycle against a schedule-based reference model, plus
// table-driven scenarios and hand-written reset / held-request sequences.
module tb_aon_timer_cfg_seq;

`ifdef AON_TIMER_CFG_SEQ_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  typedef struct packed {
    logic        wkup_en;
    logic [11:0] presc;
    logic [31:0] thold;
    logic        wdog_en;
    logic        pause;
    logic [31:0] bark;
    logic [31:0] bite;
  } tcfg_t;

  typedef struct packed {
    logic        wkc_wr;  logic [12:0] wkc_dat;
    logic        wkt_wr;  logic [31:0] wkt_dat;
    logic        wkn_wr;  logic [31:0] wkn_dat;
    logic        wdc_wr;  logic [1:0]  wdc_dat;
    logic        bark_wr; logic [31:0] bark_dat;
    logic        bite_wr; logic [31:0] bite_dat;
    logic        wdn_wr;  logic [31:0] wdn_dat;
    logic        busy;    logic        done;    logic err;
  } out_t;

  typedef struct {
    tcfg_t cfg;
    int    abort_at;
    bit    bad_bite;
    int    exp_done0;
    int    exp_done1;
    bit    exp_err;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  logic req, abort;
  logic wkup_en, wdog_en, pause;
  logic [11:0] presc;
  logic [31:0] thold, bark, bite;
  logic [31:0] rb_thold, rb_bark, rb_bite;

  logic        ack [2], busy [2], done [2], err [2];
  logic        wkc_wr [2], wkt_wr [2], wkn_wr [2], wdc_wr [2], bark_wr [2], bite_wr [2], wdn_wr [2];
  logic [12:0] wkc_dat [2];
  logic [31:0] wkt_dat [2], wkn_dat [2], bark_dat [2], bite_dat [2], wdn_dat [2];
  logic [1:0]  wdc_dat [2];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    aon_timer_cfg_seq #(.GapCycles(gi * 2)) dut (
      .clk_aon_i                 (clk),
      .rst_aon_i                 (rst),
      .req_i                     (req),
      .ack_o                     (ack[gi]),
      .abort_i                   (abort),
      .cfg_wkup_en_i             (wkup_en),
      .cfg_wkup_presc_i          (presc),
      .cfg_wkup_thold_i          (thold),
      .cfg_wdog_en_i             (wdog_en),
      .cfg_wdog_pause_i          (pause),
      .cfg_wdog_bark_i           (bark),
      .cfg_wdog_bite_i           (bite),
      .wkup_ctrl_reg_wr_o        (wkc_wr[gi]),
      .wkup_ctrl_wr_data_o       (wkc_dat[gi]),
      .wkup_thold_reg_wr_o       (wkt_wr[gi]),
      .wkup_thold_wr_data_o      (wkt_dat[gi]),
      .wkup_count_reg_wr_o       (wkn_wr[gi]),
      .wkup_count_wr_data_o      (wkn_dat[gi]),
      .wdog_ctrl_reg_wr_o        (wdc_wr[gi]),
      .wdog_ctrl_wr_data_o       (wdc_dat[gi]),
      .wdog_bark_thold_reg_wr_o  (bark_wr[gi]),
      .wdog_bark_thold_wr_data_o (bark_dat[gi]),
      .wdog_bite_thold_reg_wr_o  (bite_wr[gi]),
      .wdog_bite_thold_wr_data_o (bite_dat[gi]),
      .wdog_count_reg_wr_o       (wdn_wr[gi]),
      .wdog_count_wr_data_o      (wdn_dat[gi]),
      .rb_wkup_thold_i           (rb_thold),
      .rb_wdog_bark_i            (rb_bark),
      .rb_wdog_bite_i            (rb_bite),
      .busy_o                    (busy[gi]),
      .done_o                    (done[gi]),
      .err_o                     (err[gi])
    );
  end

  // ---------------- reference model: one sequence record per instance ----------
  bit    m_has [2];
  int    m_c   [2];   // accept cycle
  int    m_a   [2];   // abort sample cycle, -1 if none
  int    m_fin [2];   // done cycle
  bit    m_mis [2];
  tcfg_t m_cfg [2];

  function automatic int gap_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // cycles from first strobe to the last non-IDLE cycle
  function automatic int seq_len(int i);
    return 9 + 8 * gap_of(i) + V;
  endfunction

  function automatic bit idle(int i, int n);
    return !m_has[i] || (n >= m_fin[i]);
  endfunction

  function automatic tcfg_t cur_cfg();
    tcfg_t c;
    c.wkup_en = wkup_en; c.presc = presc; c.thold = thold;
    c.wdog_en = wdog_en; c.pause = pause; c.bark = bark; c.bite = bite;
    return c;
  endfunction

  function automatic out_t add_step(out_t o_in, int k, tcfg_t c);
    out_t o;
    o = o_in;
    case (k)
      0: begin o.wkc_wr = 1'b1; o.wkc_dat = {c.presc, 1'b0}; end
      1: begin o.wdc_wr = 1'b1; o.wdc_dat = {c.pause, 1'b0}; end
      2: o.wkn_wr = 1'b1;
      3: begin o.wkt_wr = 1'b1; o.wkt_dat = c.thold; end
      4: o.wdn_wr = 1'b1;
      5: begin o.bark_wr = 1'b1; o.bark_dat = c.bark; end
      6: begin o.bite_wr = 1'b1; o.bite_dat = c.bite; end
      7: begin o.wdc_wr = 1'b1; o.wdc_dat = {c.pause, c.wdog_en}; end
      8: begin o.wkc_wr = 1'b1; o.wkc_dat = {c.presc, c.wkup_en}; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t model_out(int i, int n);
    out_t o;
    int   g;
    int   k;
    o = '0;
    g = gap_of(i);
    if (!m_has[i]) return o;
    o.busy = (n > m_c[i]) && (n < m_fin[i]);
    if (n == m_fin[i]) begin
      o.done = 1'b1;
      o.err  = (m_a[i] >= 0) || ((V == 1) && m_mis[i]);
    end
    if ((m_a[i] >= 0) && (n == m_a[i] + 1)) begin
      o.wkc_wr = 1'b1; o.wkc_dat = {m_cfg[i].presc, 1'b0};
      o.wdc_wr = 1'b1; o.wdc_dat = {m_cfg[i].pause, 1'b0};
    end else if ((n > m_c[i]) && ((m_a[i] < 0) || (n <= m_a[i]))) begin
      k = n - m_c[i] - 1;
      if ((k % (g + 1) == 0) && (k / (g + 1) <= 8)) o = add_step(o, k / (g + 1), m_cfg[i]);
    end
    return o;
  endfunction

  task automatic model_step(int i, int n);
    if (rst) begin
      m_has[i] = 1'b0;
      return;
    end
    if (m_has[i] && (n == m_c[i] + seq_len(i)))
      m_mis[i] = (rb_thold != m_cfg[i].thold) || (rb_bark != m_cfg[i].bark) || (rb_bite != m_cfg[i].bite);
    if (m_has[i] && abort && (n > m_c[i]) && (n < m_fin[i]) && (m_a[i] < 0)) begin
      m_a[i]   = n;
      m_fin[i] = n + 2;
    end else if (req && idle(i, n)) begin
      m_has[i] = 1'b1;
      m_c[i]   = n;
      m_a[i]   = -1;
      m_fin[i] = n + seq_len(i) + 1;
      m_cfg[i] = cur_cfg();
      m_mis[i] = 1'b0;
    end
  endtask

  function automatic out_t pack(int i);
    out_t o;
    o.wkc_wr = wkc_wr[i];   o.wkc_dat = wkc_dat[i];
    o.wkt_wr = wkt_wr[i];   o.wkt_dat = wkt_dat[i];
    o.wkn_wr = wkn_wr[i];   o.wkn_dat = wkn_dat[i];
    o.wdc_wr = wdc_wr[i];   o.wdc_dat = wdc_dat[i];
    o.bark_wr = bark_wr[i]; o.bark_dat = bark_dat[i];
    o.bite_wr = bite_wr[i]; o.bite_dat = bite_dat[i];
    o.wdn_wr = wdn_wr[i];   o.wdn_dat = wdn_dat[i];
    o.busy = busy[i]; o.done = done[i]; o.err = err[i];
    return o;
  endfunction

  // Data is only meaningful while its strobe is high; counter-clear data must be 0 then.
  function automatic out_t norm(out_t a);
    out_t o;
    o = a;
    if (!o.wkc_wr)  o.wkc_dat  = '0;
    if (!o.wkt_wr)  o.wkt_dat  = '0;
    if (!o.wkn_wr)  o.wkn_dat  = '0;
    if (!o.wdc_wr)  o.wdc_dat  = '0;
    if (!o.bark_wr) o.bark_dat = '0;
    if (!o.bite_wr) o.bite_dat = '0;
    if (!o.wdn_wr)  o.wdn_dat  = '0;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // per-cycle monitor
  out_t mon_e, mon_a;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mon_e = '0;
        mon_a = pack(i);
      end else begin
        mon_e = model_out(i, cyc);
        mon_a = norm(pack(i));
      end
      chk($sformatf("outs dut%0d cyc%0d", i, cyc), mon_a, mon_e);
      chk($sformatf("ack dut%0d cyc%0d", i, cyc), ack[i], req & idle(i, cyc));
      model_step(i, cyc);
    end
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input tcfg_t c);
    wkup_en = c.wkup_en; presc = c.presc; thold = c.thold;
    wdog_en = c.wdog_en; pause = c.pause; bark = c.bark; bite = c.bite;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(idle(0, cyc) && idle(1, cyc)) && (t < 100)) begin
      next_cycle();
      t++;
    end
    chk("wait_idle budget", 32'(t < 100), 32'd1);
  endtask

  task automatic run_row(input int idx, input row_t r);
    int  d0, d1;
    bit  e0, e1;
    d0 = -1; d1 = -1; e0 = 1'b0; e1 = 1'b0;
    wait_idle();
    set_cfg(r.cfg);
    rb_thold = r.cfg.thold;
    rb_bark  = r.cfg.bark;
    rb_bite  = r.bad_bite ? r.cfg.bite + 32'd1 : r.cfg.bite;
    req = 1'b1;
    next_cycle();
    req = 1'b0;
    for (int rel = 1; rel <= 40; rel++) begin
      abort = (rel == r.abort_at);
      @(negedge clk);
      if (done[0] && (d0 < 0)) begin d0 = rel; e0 = err[0]; end
      if (done[1] && (d1 < 0)) begin d1 = rel; e1 = err[1]; end
      next_cycle();
    end
    abort = 1'b0;
    chk($sformatf("row%0d done cycle gap0", idx), d0, r.exp_done0);
    chk($sformatf("row%0d done cycle gap2", idx), d1, r.exp_done1);
    chk($sformatf("row%0d err gap0", idx), e0, r.exp_err);
    chk($sformatf("row%0d err gap2", idx), e1, r.exp_err);
  endtask

  row_t rows [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n0;
    int    strobes;
    tcfg_t ca, cb;

    rows[0] = '{'{1'b1, 12'h003, 32'h100, 1'b1, 1'b0, 32'h40, 32'h80}, -1, 1'b0, 10 + V, 26 + V, 1'b0};
    rows[1] = '{'{1'b0, 12'hfff, 32'hffff_ffff, 1'b1, 1'b1, 32'h1, 32'h2}, -1, 1'b0, 10 + V, 26 + V, 1'b0};
    rows[2] = '{'{1'b1, 12'h003, 32'h100, 1'b1, 1'b0, 32'h40, 32'h80}, 4, 1'b0, 6, 6, 1'b1};
    rows[3] = '{'{1'b1, 12'h5a5, 32'h1234, 1'b0, 1'b1, 32'h55, 32'haa}, 1, 1'b0, 3, 3, 1'b1};
    rows[4] = '{'{1'b1, 12'h001, 32'h9, 1'b1, 1'b1, 32'h7, 32'h8}, 9, 1'b0, 11, 11, 1'b1};
    rows[5] = '{'{1'b1, 12'h003, 32'h100, 1'b1, 1'b0, 32'h40, 32'h80}, -1, 1'b1, 10 + V, 26 + V, (V == 1)};

    rst = 1'b1; req = 1'b0; abort = 1'b0;
    set_cfg('0);
    rb_thold = '0; rb_bark = '0; rb_bite = '0;
    m_has[0] = 1'b0; m_has[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset outs gap0", pack(0), '0);
    chk("reset outs gap2", pack(1), '0);
    rst = 1'b0;
    next_cycle();

    for (int r = 0; r < 6; r++) run_row(r, rows[r]);

    // Held request: no ack while busy, no relatch, accepted in the first IDLE cycle.
    wait_idle();
    ca = '{1'b1, 12'h005, 32'h10, 1'b1, 1'b0, 32'h20, 32'h30};
    cb = '{1'b0, 12'h0aa, 32'hdead, 1'b0, 1'b1, 32'hbeef, 32'hcafe};
    set_cfg(ca);
    rb_thold = ca.thold; rb_bark = ca.bark; rb_bite = ca.bite;
    req = 1'b1;
    n0 = cyc;
    next_cycle();
    next_cycle();
    set_cfg(cb);
    while (cyc < n0 + 4) next_cycle();
    @(negedge clk);
    chk("held req ack while busy", ack[0], 1'b0);
    chk("no relatch thold", wkt_dat[0], ca.thold);
    while (cyc < n0 + 10 + V) next_cycle();
    @(negedge clk);
    chk("held req ack after done", ack[0], 1'b1);
    next_cycle();
    req = 1'b0;
    wait_idle();

    // Reset in the middle of a sequence.
    set_cfg(ca);
    req = 1'b1;
    next_cycle();
    req = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    rst = 1'b1;
    #1;
    chk("mid reset outs gap0", pack(0), '0);
    chk("mid reset outs gap2", pack(1), '0);
    next_cycle();
    rst = 1'b0;
    strobes = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        strobes += int'(wkc_wr[i]) + int'(wkt_wr[i]) + int'(wkn_wr[i]) + int'(wdc_wr[i]) +
                   int'(bark_wr[i]) + int'(bite_wr[i]) + int'(wdn_wr[i]) + int'(done[i]);
      next_cycle();
    end
    chk("strobes after reset", strobes, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      req   = ($urandom_range(3) == 0);
      abort = ($urandom_range(24) == 0);
      set_cfg({1'($urandom), 12'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom});
      if ($urandom_range(4) == 0) begin
        rb_thold = $urandom; rb_bark = $urandom; rb_bite = $urandom;
      end else begin
        int s;
        s = $urandom_range(1);
        rb_thold = m_cfg[s].thold; rb_bark = m_cfg[s].bark; rb_bite = m_cfg[s].bite;
      end
      next_cycle();
    end
    req = 1'b0;
    abort = 1'b0;
    wait_idle();
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
